im_fetch_ctrl: RTL and testbench
================================

# im_fetch_ctrl

Sequencer for the instruction-memory SRAM, which has active-low CSB/WRB, an 8-bit address bus and a bidirectional data bus with a 10 ns access delay. Sits between the core's fetch stage and the IM, and shares the IM between two requesters: sequential instruction fetch and a program-loader write port. Generates all SRAM strobes with fixed wait states, captures read data into an instruction register, and handshakes instructions to the core.

## Interface
- ADDR_W, 8, IM address width
- DATA_W, 8, IM data width
- WAIT_CYCLES, 2, clock cycles the strobe is held per access (≥1; covers 10 ns access delay plus margin)
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  allow fetches
- redirect  in  1  load redirect_pc into PC (branch/jump)
- redirect_pc  in  ADDR_W  new fetch address
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  instr is valid; held until accepted
- instr_ready  in  1  core accepts instr
- ld_req  in  1  loader write request; hold until ld_ack
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- ld_ack  out  1  one-cycle pulse: write done
- im_csb  out  1  IM chip select, active low
- im_wrb  out  1  IM write strobe, active low
- im_abus  out  ADDR_W  IM address
- im_dout  out  DATA_W  write data to top-level tristate
- im_doe  out  1  tristate enable for im_dout
- im_din  in  DATA_W  IM data bus as read back

## Operation
- States: IDLE, RD, VALID, WR_SETUP, WR_PULSE, WR_HOLD. All outputs are registered.
- IDLE: CSB=1, WRB=1, doe=0. Priority: ld_req → WR_SETUP; else fetch_en → RD with im_abus=PC; else stay.
- RD: CSB=0, WRB=1, doe=0, for WAIT_CYCLES cycles (down-counter). At the edge ending the last RD cycle: instr←im_din, instr_pc←PC; go to VALID.
- VALID: CSB=1, instr_valid=1. On instr_valid&instr_ready: PC←PC+1 (mod 2^ADDR_W; 255→0), then IDLE. Otherwise hold VALID with instr stable.
- WR_SETUP (1 cycle): CSB=1, WRB=1, doe=1, im_abus=ld_addr, im_dout=ld_data.
- WR_PULSE (WAIT_CYCLES cycles): CSB=0, WRB=0, doe=1, address and data stable.
- WR_HOLD (1 cycle): CSB=1, WRB=1, doe=1, ld_ack=1; then IDLE.
- CSB is never low with WRB=1 while doe=1, so no bus contention. Address and data never change while CSB=0.
- redirect, any state: PC←redirect_pc; takes precedence over increment.
  - In RD: abort the read (capture suppressed), go to IDLE.
  - In VALID: drop instr_valid next cycle, go to IDLE; a same-cycle handshake is ignored.
  - In WR_*: the write completes unaffected.
- fetch_en low does not abort an in-progress RD/VALID.
- Reset values: state=IDLE, PC=RESET_PC, im_csb=1, im_wrb=1, im_doe=0, im_abus=0, im_dout=0, instr=0, instr_pc=0, instr_valid=0, ld_ack=0. Reset mid-access aborts immediately; CSB/WRB go high the next cycle.

## Timing
- Read latency: fetch_en sampled in IDLE at cycle N; CSB low N+1..N+WAIT_CYCLES; instr_valid high at N+WAIT_CYCLES+1.
- Throughput with instr_ready held high: one instruction per WAIT_CYCLES+2 cycles. With WAIT_CYCLES=2, 4 cycles.
- Write: ld_req sampled in IDLE at cycle N; ld_ack at N+WAIT_CYCLES+2; next access at N+WAIT_CYCLES+3 at the earliest.
- A loader request arriving during RD/VALID waits for IDLE.

## Structure
- Package im_ctrl_pkg: state enum, ADDR_W/DATA_W defaults, IM_CSB_IDLE/IM_WRB_IDLE constants.
- Sub-module im_wait_ctr: loadable down-counter with a zero flag, used by both RD and WR_PULSE.
- Top-level wrapper owns the inout: DATABUS = im_doe ? im_dout : 'z; im_din = DATABUS.

## Test plan
- Reset, then fetch_en=1 with ready high and an IM model holding 0x11,0x22,0x33 at addr 0..2 → instr 0x11,0x22,0x33 with instr_pc 0,1,2; one valid every 4 cycles; CSB high between reads.
- Hold instr_ready=0 for 5 cycles → instr_valid stays 1, instr/PC stable, no IM access.
- ld_req addr 0x40 data 0xA5 while a read is in RD → read completes first. Then setup/pulse/hold sequence; WRB low exactly 2 cycles with CSB low; ld_ack once; readback of 0x40 = 0xA5.
- redirect to 0x80 during RD cycle 1 → no instr_valid for the old address; next instr_pc=0x80.
- PC at 0xFF, accept → next fetch address 0x00.
- Assert rst during WR_PULSE → next cycle CSB=1, WRB=1, doe=0, PC=RESET_PC, ld_ack never pulses.

Source files
------------

// File: rtl/im_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch/load sequencer.
package im_ctrl_pkg;

    localparam int unsigned IM_ADDR_W   = 8;
    localparam int unsigned IM_DATA_W   = 8;
    localparam logic        IM_CSB_IDLE = 1'b1;
    localparam logic        IM_WRB_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_VALID    = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } im_state_e;

    // Width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/im_wait_ctr.sv
// Loadable down-counter with a zero flag; times strobe wait states.
module im_wait_ctr #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/im_fetch_ctrl.sv
// IM SRAM sequencer: arbitrates sequential fetch and loader writes, drives
// registered strobes; the board-level tristate is DATABUS = im_doe ? im_dout : 'z.
module im_fetch_ctrl
    import im_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_W      = IM_ADDR_W,
    parameter int unsigned          DATA_W      = IM_DATA_W,
    parameter int unsigned          WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              im_csb,
    output logic              im_wrb,
    output logic [ADDR_W-1:0] im_abus,
    output logic [DATA_W-1:0] im_dout,
    output logic              im_doe,
    input  logic [DATA_W-1:0] im_din
);

    localparam int unsigned      CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    im_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              ack_q, ack_d;
    logic              csb_q, csb_d;
    logic              wrb_q, wrb_d;
    logic              doe_q, doe_d;
    logic [ADDR_W-1:0] abus_q, abus_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    im_wait_ctr #(
        .CNT_W (CNT_W)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        abus_d     = abus_q;
        dout_d     = dout_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld_req) begin
                    state_d  = ST_WR_SETUP;
                    abus_d   = ld_addr;
                    dout_d   = ld_data;
                end else if (fetch_en) begin
                    state_d  = ST_RD;
                    // A same-cycle redirect already owns the PC, so fetch from it.
                    abus_d   = redirect ? redirect_pc : pc_q;
                    cnt_load = 1'b1;
                end
            end
            ST_RD: begin
                if (redirect) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d    = ST_VALID;
                    instr_d    = im_din;
                    instr_pc_d = abus_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    state_d = ST_IDLE;
                end else if (instr_ready) begin
                    state_d = ST_IDLE;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_d  = ST_WR_PULSE;
                cnt_load = 1'b1;
            end
            ST_WR_PULSE: begin
                if (cnt_zero) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_pc;
        end

        // Strobes are decoded from the next state so every pin is a flop output.
        csb_d = IM_CSB_IDLE;
        wrb_d = IM_WRB_IDLE;
        doe_d = 1'b0;
        case (state_d)
            ST_RD: begin
                csb_d = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                doe_d = 1'b1;
            end
            ST_WR_PULSE: begin
                csb_d = 1'b0;
                wrb_d = 1'b0;
                doe_d = 1'b1;
            end
            default: begin
                csb_d = IM_CSB_IDLE;
            end
        endcase
        valid_d = (state_d == ST_VALID);
        ack_d   = (state_d == ST_WR_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            csb_q      <= IM_CSB_IDLE;
            wrb_q      <= IM_WRB_IDLE;
            doe_q      <= 1'b0;
            abus_q     <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            csb_q      <= csb_d;
            wrb_q      <= wrb_d;
            doe_q      <= doe_d;
            abus_q     <= abus_d;
            dout_q     <= dout_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign ld_ack      = ack_q;
    assign im_csb      = csb_q;
    assign im_wrb      = wrb_q;
    assign im_doe      = doe_q;
    assign im_abus     = abus_q;
    assign im_dout     = dout_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl with a behavioural IM SRAM model.
module tb_im_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch_en = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       ld_req = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;
    logic       ld_ack;
    logic       im_csb;
    logic       im_wrb;
    logic [7:0] im_abus;
    logic [7:0] im_dout;
    logic       im_doe;
    logic [7:0] im_din;

    im_fetch_ctrl #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .WAIT_CYCLES (2),
        .RESET_PC    (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .im_csb      (im_csb),
        .im_wrb      (im_wrb),
        .im_abus     (im_abus),
        .im_dout     (im_dout),
        .im_doe      (im_doe),
        .im_din      (im_din)
    );

    always #5 clk = ~clk;

    // IM model: reads while selected and not writing, writes on strobe.
    logic [7:0] mem [256];
    assign im_din = (!im_csb && im_wrb && !im_doe) ? mem[im_abus] : 8'hEE;
    always @(posedge clk) begin
        if (!rst && !im_csb && !im_wrb && im_doe) mem[im_abus] = im_dout;
    end

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   hs_n = 0;
    int   csb_low_cnt = 0;
    int   wrb_low_cnt = 0;
    int   wr_strobe_cnt = 0;
    int   ack_cnt = 0;
    logic       prev_csb_low = 1'b0;
    logic [7:0] prev_abus = 8'h00;
    logic [7:0] prev_dout = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and watches bus protocol.
    always @(negedge clk) begin
        if (rst) begin
            prev_csb_low = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                hs_n++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", {16'h0, instr_pc, instr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instr", {24'h0, instr}, {24'h0, e.instr});
                    check("instr_pc", {24'h0, instr_pc}, {24'h0, e.pc});
                end
            end
            if (!im_csb) csb_low_cnt++;
            if (!im_wrb) wrb_low_cnt++;
            if (!im_wrb && !im_csb) wr_strobe_cnt++;
            if (ld_ack) ack_cnt++;
            if (!im_csb && im_doe) check("no_contention_wrb", {31'h0, im_wrb}, 32'h0);
            if (prev_csb_low && !im_csb) begin
                check("abus_stable", {24'h0, im_abus}, {24'h0, prev_abus});
                if (im_doe) check("dout_stable", {24'h0, im_dout}, {24'h0, prev_dout});
            end
            prev_csb_low = !im_csb;
            prev_abus    = im_abus;
            prev_dout    = im_dout;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_n < target && n < budget) begin
            step();
            n++;
        end
        if (hs_n < target) check("hs_timeout", hs_n, target);
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] a);
        exp_t e;
        e.instr = d;
        e.pc    = a;
        exp_q.push_back(e);
    endtask

    initial begin
        int n;
        int csb_snap;
        int ack_snap;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44; mem[8'h04] = 8'h55; mem[8'h41] = 8'h77;
        mem[8'h80] = 8'h5A; mem[8'hFF] = 8'hF0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csb", {31'h0, im_csb}, 32'h1);
        check("rst_wrb", {31'h0, im_wrb}, 32'h1);
        check("rst_doe", {31'h0, im_doe}, 32'h0);
        check("rst_abus", {24'h0, im_abus}, 32'h0);
        check("rst_dout", {24'h0, im_dout}, 32'h0);
        check("rst_instr", {24'h0, instr}, 32'h0);
        check("rst_instr_pc", {24'h0, instr_pc}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_ack", {31'h0, ld_ack}, 32'h0);
        step();
        rst = 1'b0;

        // Three sequential fetches, ready held high
        csb_low_cnt = 0;
        push(8'h11, 8'h00); push(8'h22, 8'h01); push(8'h33, 8'h02);
        fetch_en = 1'b1;
        wait_hs(3, 40);
        fetch_en = 1'b0;
        check("csb_low_cycles_3_reads", csb_low_cnt, 6);
        if (hs_cyc.size() >= 3) begin
            check("period_0_1", hs_cyc[1] - hs_cyc[0], 4);
            check("period_1_2", hs_cyc[2] - hs_cyc[1], 4);
        end

        // Stall: valid held, no IM access
        instr_ready = 1'b0;
        push(8'h44, 8'h03);
        fetch_en = 1'b1;
        n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        fetch_en = 1'b0;
        csb_snap = csb_low_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'h0, instr_valid}, 32'h1);
        end
        check("stall_instr", {24'h0, instr}, 32'h44);
        check("stall_pc", {24'h0, instr_pc}, 32'h03);
        check("stall_no_access", csb_low_cnt - csb_snap, 0);
        instr_ready = 1'b1;
        wait_hs(4, 10);

        // Loader request during RD waits for the read to finish
        wrb_low_cnt = 0; wr_strobe_cnt = 0; ack_cnt = 0;
        push(8'h55, 8'h04);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        ld_req = 1'b1; ld_addr = 8'h40; ld_data = 8'hA5;
        n = 0;
        while (!ld_ack && n < 30) begin step(); n++; end
        check("ack_seen", {31'h0, ld_ack}, 32'h1);
        check("read_before_write", hs_n, 5);
        ld_req = 1'b0;
        repeat (3) step();
        check("wrb_low_cycles", wrb_low_cnt, 2);
        check("wrb_with_csb_cycles", wr_strobe_cnt, 2);
        check("ack_pulses", ack_cnt, 1);

        // Read back the written location
        redirect = 1'b1; redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        push(8'hA5, 8'h40);
        fetch_en = 1'b1;
        wait_hs(6, 20);
        fetch_en = 1'b0;

        // Redirect during RD cycle 1 aborts the read at 0x41
        step();
        fetch_en = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 8'h80;
        step();
        redirect = 1'b0;
        push(8'h5A, 8'h80);
        wait_hs(7, 20);
        fetch_en = 1'b0;

        // PC wraps 0xFF -> 0x00
        redirect = 1'b1; redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        push(8'hF0, 8'hFF); push(8'h11, 8'h00);
        fetch_en = 1'b1;
        wait_hs(9, 30);
        fetch_en = 1'b0;

        // Reset during WR_PULSE
        ack_snap = ack_cnt;
        ld_req = 1'b1; ld_addr = 8'h10; ld_data = 8'h3C;
        n = 0;
        do begin step(); n++; end while (im_wrb && n < 10);
        check("pulse_reached", {31'h0, im_wrb}, 32'h0);
        rst = 1'b1;
        ld_req = 1'b0;
        step();
        check("rstwr_csb", {31'h0, im_csb}, 32'h1);
        check("rstwr_wrb", {31'h0, im_wrb}, 32'h1);
        check("rstwr_doe", {31'h0, im_doe}, 32'h0);
        check("rstwr_ack", {31'h0, ld_ack}, 32'h0);
        rst = 1'b0;
        push(8'h11, 8'h00);
        fetch_en = 1'b1;
        wait_hs(10, 20);
        fetch_en = 1'b0;
        repeat (5) step();
        check("no_ack_after_reset", ack_cnt - ack_snap, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
